corevx_ptw: RTL and testbench

Sv32 hardware page-table walker for the corevx cache. On a TLB miss, the cache controller hands this block a virtual page number. The block sequences one or two 32-bit PTE reads on a dedicated memory read port and returns one of three results: the physical page number plus the 8-bit accesstag for the TLB fill, a pagefault, or an access fault. Permission checks on the returned accesstag (U/SUM/MXR/A/D/R/W/X versus command and privilege) are not done here; the existing combinational pagefault checker applies them to the TLB output.

---
 rtl/corevx_ptw_pkg.sv | 47 ++++
 rtl/corevx_ptw_pte_check.sv | 52 +++++
 rtl/corevx_ptw.sv | 122 ++++++++++++
 tb/tb_corevx_ptw.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/corevx_ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : corevx_ptw_defs (package)
// Description : Shared types and constants for the Sv32 page-table walker:
//               FSM state encoding, PTE bit indices (also used by the TLB
//               accesstag), PTE PPN field position and the Sv32 level count.
// Revision    : 1.0 - initial release
// ============================================================================
package corevx_ptw_defs;

    // Walker states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ptw_state_t;

    // PTE / accesstag bit indices
    localparam int unsigned c_PTE_V = 0;
    localparam int unsigned c_PTE_R = 1;
    localparam int unsigned c_PTE_W = 2;
    localparam int unsigned c_PTE_X = 3;
    localparam int unsigned c_PTE_U = 4;
    localparam int unsigned c_PTE_G = 5;
    localparam int unsigned c_PTE_A = 6;
    localparam int unsigned c_PTE_D = 7;

    // PTE PPN field [31:10]
    localparam int unsigned c_PTE_PPN_LSB = 10;
    localparam int unsigned c_PTE_PPN_MSB = 31;
    localparam int unsigned c_PPN_W       = c_PTE_PPN_MSB - c_PTE_PPN_LSB + 1;
    localparam int unsigned c_VPN_SEG_W   = 10;

    // Sv32 has two translation levels
    localparam int unsigned c_SV32_LEVELS = 2;
    localparam int unsigned c_LEVEL_W     = $clog2(c_SV32_LEVELS);
    typedef logic [c_LEVEL_W-1:0] level_t;
    localparam level_t c_LEVEL_TOP = level_t'(c_SV32_LEVELS - 1);

    // Extract the PPN field of a PTE
    function automatic logic [c_PPN_W-1:0] pte_ppn(input logic [31:0] pte);
        return pte[c_PTE_PPN_MSB:c_PTE_PPN_LSB];
    endfunction

endpackage : corevx_ptw_defs
`default_nettype wire

// File: rtl/corevx_ptw_pte_check.sv
`default_nettype none
// ============================================================================
// Module      : corevx_ptw_pte_check
// Description : Combinational classification of one fetched PTE into
//               leaf / next-level pointer / pagefault / accessfault.
//               Exactly one output is high for every input combination.
// Revision    : 1.0 - initial release
// ============================================================================
module corevx_ptw_pte_check
    import corevx_ptw_defs::*;
(
    input  logic [31:0] i_pte,
    input  level_t      i_level,
    input  logic        i_error,
    output logic        o_leaf,
    output logic        o_next,
    output logic        o_pagefault,
    output logic        o_accessfault
);

    logic [c_PPN_W-1:0] w_ppn;
    logic               w_unused_bits;

    assign w_ppn         = pte_ppn(i_pte);
    // U/G/A/D and RSW are carried to the TLB but do not affect the walk
    assign w_unused_bits = ^i_pte[9:4];

    // Bus error dominates; then invalid encodings; then leaf vs pointer
    always_comb begin
        o_leaf        = 1'b0;
        o_next        = 1'b0;
        o_pagefault   = 1'b0;
        o_accessfault = 1'b0;
        if (i_error) begin
            o_accessfault = 1'b1;
        end else if (!i_pte[c_PTE_V] || (!i_pte[c_PTE_R] && i_pte[c_PTE_W])) begin
            o_pagefault = 1'b1;
        end else if (i_pte[c_PTE_R] || i_pte[c_PTE_X]) begin
            // A top-level leaf is a 4 MiB superpage and must be aligned
            if ((i_level != '0) && (w_ppn[c_VPN_SEG_W-1:0] != '0))
                o_pagefault = 1'b1;
            else
                o_leaf = 1'b1;
        end else if (i_level == '0) begin
            o_pagefault = 1'b1;
        end else begin
            o_next = 1'b1;
        end
    end

endmodule : corevx_ptw_pte_check
`default_nettype wire

// File: rtl/corevx_ptw.sv
`default_nettype none
// ============================================================================
// Module      : corevx_ptw
// Description : Sv32 hardware page-table walker. Takes a VPN on a TLB miss,
//               reads one or two PTEs on a dedicated read port and returns
//               the leaf PPN + accesstag, a pagefault or an access fault.
// Revision    : 1.0 - initial release
// ============================================================================
module corevx_ptw
    import corevx_ptw_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] csr_satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_access_bits,
    output logic        resolve_busy,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    input  logic        mem_error
);

    ptw_state_t         r_state;
    ptw_state_t         w_next_state;
    logic [19:0]        r_vpn;
    logic [c_PPN_W-1:0] r_table_ppn;
    level_t             r_level;
    logic               r_pagefault;
    logic               r_accessfault;
    logic [c_PPN_W-1:0] r_ppn;
    logic [7:0]         r_bits;

    logic [c_VPN_SEG_W-1:0] w_vpn_seg;
    logic [c_PPN_W-1:0]     w_pte_ppn;
    logic [c_PPN_W-1:0]     w_leaf_ppn;
    logic                   w_rsp;
    logic                   w_leaf;
    logic                   w_next;
    logic                   w_pagefault;
    logic                   w_accessfault;
    logic                   w_unused_rsw;

    assign w_vpn_seg    = (r_level != '0) ? r_vpn[19:10] : r_vpn[9:0];
    assign w_pte_ppn    = pte_ppn(mem_readdata);
    // Superpage leaf: low PPN bits come from the untranslated vpn0
    assign w_leaf_ppn   = (r_level != '0) ? {w_pte_ppn[c_PPN_W-1:c_VPN_SEG_W], r_vpn[9:0]}
                                          : w_pte_ppn;
    assign w_rsp        = (r_state == ST_WAIT) && mem_readdatavalid;
    assign w_unused_rsw = ^mem_readdata[9:8];

    corevx_ptw_pte_check u_pte_check (
        .i_pte         (mem_readdata),
        .i_level       (r_level),
        .i_error       (mem_error),
        .o_leaf        (w_leaf),
        .o_next        (w_next),
        .o_pagefault   (w_pagefault),
        .o_accessfault (w_accessfault)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (resolve_request) w_next_state = ST_ISSUE;
            ST_ISSUE: if (!mem_waitrequest) w_next_state = ST_WAIT;
            ST_WAIT:  if (w_rsp) w_next_state = w_next ? ST_ISSUE : ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Walk context and result registers; results only change on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpn         <= '0;
            r_table_ppn   <= '0;
            r_level       <= '0;
            r_pagefault   <= 1'b0;
            r_accessfault <= 1'b0;
            r_ppn         <= '0;
            r_bits        <= '0;
        end else if ((r_state == ST_IDLE) && resolve_request) begin
            r_vpn       <= resolve_virtual_address;
            r_table_ppn <= csr_satp_ppn;
            r_level     <= c_LEVEL_TOP;
        end else if (w_rsp && w_next) begin
            r_table_ppn <= w_pte_ppn;
            r_level     <= '0;
        end else if (w_rsp) begin
            r_pagefault   <= w_pagefault;
            r_accessfault <= w_accessfault;
            r_ppn         <= w_leaf ? w_leaf_ppn : '0;
            r_bits        <= w_leaf ? mem_readdata[7:0] : '0;
        end
    end

    assign mem_read                 = (r_state == ST_ISSUE);
    assign mem_address              = mem_read ? {r_table_ppn, w_vpn_seg, 2'b00} : '0;
    assign resolve_done             = (r_state == ST_DONE);
    assign resolve_busy             = (r_state != ST_IDLE);
    assign resolve_pagefault        = r_pagefault;
    assign resolve_accessfault      = r_accessfault;
    assign resolve_physical_address = r_ppn;
    assign resolve_access_bits      = r_bits;

endmodule : corevx_ptw
`default_nettype wire

// File: tb/tb_corevx_ptw.sv
`default_nettype none
// ============================================================================
// Module      : tb_corevx_ptw
// Description : Directed self-checking bench for the Sv32 page-table walker.
//               The bench plays the memory side and checks addresses,
//               latencies and results against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corevx_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] csr_satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic        resolve_busy;
    logic        mem_read;
    logic [33:0] mem_address;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic        mem_error;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    corevx_ptw dut (
        .clk                      (clk),
        .rst                      (rst),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .csr_satp_ppn             (csr_satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .resolve_busy             (resolve_busy),
        .mem_read                 (mem_read),
        .mem_address              (mem_address),
        .mem_waitrequest          (mem_waitrequest),
        .mem_readdatavalid        (mem_readdatavalid),
        .mem_readdata             (mem_readdata),
        .mem_error                (mem_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {60'd0, resolve_done, resolve_busy, resolve_pagefault, resolve_accessfault}, 64'd0);
        chk({tag, "_mem"}, {29'd0, mem_read, mem_address}, 64'd0);
        chk({tag, "_res"}, {34'd0, resolve_physical_address, resolve_access_bits}, 64'd0);
    endtask

    // One complete walk; the bench serves nreads PTEs (a1/p1 then a0/p0)
    task automatic walk(input string tag, input logic [19:0] vpn, input logic [21:0] satp,
                        input int nreads, input logic [33:0] a1, input logic [31:0] p1,
                        input logic [33:0] a0, input logic [31:0] p0, input logic err,
                        input int ws, input int dly, input bit pulse,
                        input logic pf, input logic af, input logic [21:0] ppn,
                        input logic [7:0] bits, input int lat);
        int t0;
        int k;
        logic [33:0] ea;
        logic [31:0] ed;
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = vpn;
        csr_satp_ppn            = satp;
        t0 = cyc;
        @(negedge clk);
        if (pulse) resolve_request = 1'b0;
        for (int r = 0; r < nreads; r++) begin
            ea = (r == 0) ? a1 : a0;
            ed = (r == 0) ? p1 : p0;
            k = 0;
            while (!mem_read && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk({tag, "_rd"}, {63'd0, mem_read}, 64'd1);
            for (int i = 0; i < ws; i++) begin
                mem_waitrequest = 1'b1;
                if (pulse) resolve_request = (i == 1);
                chk({tag, "_addr_stall"}, {30'd0, mem_address}, {30'd0, ea});
                @(negedge clk);
            end
            mem_waitrequest = 1'b0;
            resolve_request = pulse ? 1'b0 : 1'b1;
            chk({tag, "_addr"}, {30'd0, mem_address}, {30'd0, ea});
            @(negedge clk);
            repeat (dly) @(negedge clk);
            mem_readdatavalid = 1'b1;
            mem_readdata      = ed;
            mem_error         = (r == nreads - 1) ? err : 1'b0;
            @(negedge clk);
            mem_readdatavalid = 1'b0;
            mem_readdata      = '0;
            mem_error         = 1'b0;
        end
        k = 0;
        while (!resolve_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, {63'd0, resolve_done}, 64'd1);
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
        chk({tag, "_pf"}, {63'd0, resolve_pagefault}, {63'd0, pf});
        chk({tag, "_af"}, {63'd0, resolve_accessfault}, {63'd0, af});
        chk({tag, "_ppn"}, {42'd0, resolve_physical_address}, {42'd0, ppn});
        chk({tag, "_bits"}, {56'd0, resolve_access_bits}, {56'd0, bits});
        resolve_request = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, resolve_done, resolve_busy}, 64'd0);
        chk({tag, "_hold"}, {42'd0, resolve_physical_address}, {42'd0, ppn});
        if (pulse) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_no_rewalk"}, {62'd0, resolve_busy, mem_read}, 64'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                     = 1'b1;
        resolve_request         = 1'b0;
        resolve_virtual_address = '0;
        csr_satp_ppn            = '0;
        mem_waitrequest         = 1'b0;
        mem_readdatavalid       = 1'b0;
        mem_readdata            = '0;
        mem_error               = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Two-level walk to a 4 KiB leaf
        walk("two_level", 20'h00401, 22'h00001, 2, 34'h1004, 32'h00000C01,
             34'h3004, 32'h000400CF, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 22'h00100, 8'hCF, 5);
        // Aligned superpage
        walk("superpage", 20'h00123, 22'h00002, 1, 34'h2000, 32'h2000000F,
             34'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 22'h80123, 8'h0F, 3);
        // Misaligned superpage
        walk("misaligned", 20'h00123, 22'h00002, 1, 34'h2000, 32'h0000040F,
             34'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h00, 3);
        // Invalid PTE
        walk("v_zero", 20'h00123, 22'h00002, 1, 34'h2000, 32'h00000C00,
             34'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h00, 3);
        // W without R
        walk("w_no_r", 20'h00123, 22'h00002, 1, 34'h2000, 32'h00000005,
             34'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h00, 3);
        // Pointer at level 0
        walk("l0_pointer", 20'h00401, 22'h00001, 2, 34'h1004, 32'h00000C01,
             34'h3004, 32'h00000001, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h00, 5);
        // Bus error on an otherwise valid leaf
        walk("bus_error", 20'h00123, 22'h00002, 1, 34'h2000, 32'h2000000F,
             34'h0, 32'h0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 22'h0, 8'h00, 3);
        // 3 stall cycles, 2 response delay cycles, stray request mid-walk
        walk("stall_delay", 20'h00123, 22'h00002, 1, 34'h2000, 32'h2000000F,
             34'h0, 32'h0, 1'b0, 3, 2, 1'b1, 1'b0, 1'b0, 22'h80123, 8'h0F, 8);

        // Reset while waiting for a response, then a stale response
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = 20'h00401;
        csr_satp_ppn            = 22'h00001;
        @(negedge clk);
        resolve_request = 1'b0;
        chk("rst_walk_issue", {30'd0, mem_address}, 64'h1004);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_wait");
        @(negedge clk);
        rst               = 1'b0;
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h2000000F;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        @(negedge clk);
        chk_all_zero("late_rsp");

        walk("after_reset", 20'h00123, 22'h00002, 1, 34'h2000, 32'h2000000F,
             34'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 22'h80123, 8'h0F, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_corevx_ptw
`default_nettype wire
